punc_mem_arbiter: RTL and testbench

- Shares the single PUnC memory port between two requesters: the processor (fetch/load/store path of the control FSM) and a program loader/debug master.
- Decides per-cycle ownership with round-robin and a burst limit, and muxes address, write enable and write data to memory.
- Returns read data with a fixed one-cycle latency, and provides a lock that freezes processor access for program loading.

---
 rtl/punc_mem_arbiter_if.sv | 25 ++
 rtl/punc_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_punc_mem_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_mem_arbiter_if.sv
// Requester-side memory bus: one instance per master sharing the PUnC memory.
// The requester holds req/we/addr/wdata until gnt; read data returns one cycle
// after the grant together with rvalid.
interface punc_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Two-master arbiter for the single PUnC memory port.
// Round-robin with a burst limit between the processor and the program loader,
// one-cycle read return with per-requester hold registers, and a loader lock
// that shuts the processor out while a program is being written.
module punc_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    punc_mem_arbiter_if.slave   cpu,
    punc_mem_arbiter_if.slave   ldr,
    input  logic                ldr_lock,
    output logic                lock_ack,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_w_en,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    owner_t            owner;
    owner_t            owner_next;
    owner_t            winner;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  burst_next;
    logic              burst_open;
    logic              cpu_elig;
    logic              ldr_elig;
    logic [ADDR_W-1:0] addr_shadow;
    logic [DATA_W-1:0] wdata_shadow;
    logic              cpu_rvalid_q;
    logic              ldr_rvalid_q;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] ldr_hold;
    logic              lock_ack_q;

    // Pick this cycle's winner and the owner/burst bookkeeping for next cycle;
    // nothing is granted while reset is held so no access slips out.
    always_comb begin
        cpu_elig   = cpu.req & ~ldr_lock & ~rst;
        ldr_elig   = ldr.req & ~rst;
        burst_open = (burst_cnt < BURST_MAX);
        winner     = OWN_NONE;
        owner_next = OWN_NONE;
        burst_next = '0;

        if (cpu_elig && ldr_elig) begin
            if (owner != OWN_NONE && burst_open)
                winner = owner;
            else
                winner = (owner == OWN_LDR) ? OWN_CPU : OWN_LDR;
        end else if (cpu_elig) begin
            winner = OWN_CPU;
        end else if (ldr_elig) begin
            winner = OWN_LDR;
        end

        if (winner == OWN_NONE) begin
            owner_next = OWN_NONE;
            burst_next = '0;
        end else if (winner == owner) begin
            owner_next = owner;
            burst_next = burst_open ? burst_cnt + 1'b1 : burst_cnt;
        end else begin
            owner_next = winner;
            burst_next = CNT_W'(1);
        end
    end

    // Steer the winner onto the memory bus and return read data to requesters.
    always_comb begin
        cpu.gnt   = 1'b0;
        ldr.gnt   = 1'b0;
        mem_addr  = addr_shadow;
        mem_wdata = wdata_shadow;
        mem_w_en  = 1'b0;

        case (winner)
            OWN_CPU: begin
                cpu.gnt   = 1'b1;
                mem_addr  = cpu.addr;
                mem_wdata = cpu.wdata;
                mem_w_en  = cpu.we;
            end
            OWN_LDR: begin
                ldr.gnt   = 1'b1;
                mem_addr  = ldr.addr;
                mem_wdata = ldr.wdata;
                mem_w_en  = ldr.we;
            end
            default: ;
        endcase

        cpu.rvalid = cpu_rvalid_q & ~rst;
        ldr.rvalid = ldr_rvalid_q & ~rst;
        cpu.rdata  = (cpu_rvalid_q & ~rst) ? mem_rdata : cpu_hold;
        ldr.rdata  = (ldr_rvalid_q & ~rst) ? mem_rdata : ldr_hold;
        lock_ack   = lock_ack_q;
    end

    // Arbitration state, bus shadows, read-return flags and hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= OWN_NONE;
            burst_cnt    <= '0;
            addr_shadow  <= '0;
            wdata_shadow <= '0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            cpu_hold     <= '0;
            ldr_hold     <= '0;
            lock_ack_q   <= 1'b0;
        end else begin
            owner     <= owner_next;
            burst_cnt <= burst_next;
            if (winner != OWN_NONE) begin
                addr_shadow  <= mem_addr;
                wdata_shadow <= mem_wdata;
            end
            cpu_rvalid_q <= (winner == OWN_CPU) & ~cpu.we;
            ldr_rvalid_q <= (winner == OWN_LDR) & ~ldr.we;
            if (cpu_rvalid_q)
                cpu_hold <= mem_rdata;
            if (ldr_rvalid_q)
                ldr_hold <= mem_rdata;
            lock_ack_q <= ldr_lock & ~cpu_rvalid_q;
        end
    end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter: directed scenarios plus a
// randomized run compared against a behavioural reference model.
module tb_punc_mem_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ldr_lock = 1'b0;
    logic        lock_ack;
    logic [15:0] mem_addr;
    logic        mem_w_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    punc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
    punc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ldr_if ();

    punc_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_if),
        .ldr      (ldr_if),
        .ldr_lock (ldr_lock),
        .lock_ack (lock_ack),
        .mem_addr (mem_addr),
        .mem_w_en (mem_w_en),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-up memory contents; 0x3000 holds 0x1234 for the first read scenario.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5C3);
    endfunction

    // Memory attached to the DUT, driven only by the DUT's bus outputs.
    logic [15:0] tb_arr [65536];
    bit          tb_wr  [65536];
    always @(posedge clk) begin
        if (mem_w_en) begin
            tb_arr[mem_addr] <= mem_wdata;
            tb_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= tb_wr[mem_addr] ? tb_arr[mem_addr] : init_word(mem_addr);
    end

    // Reference model: 0 = nobody, 1 = processor, 2 = loader.
    logic [15:0] model_arr [65536];
    bit          model_wr  [65536];
    int          m_owner = 0;
    int          m_burst = 0;
    logic [15:0] m_last_addr = '0;
    logic [15:0] m_last_wdata = '0;
    logic        m_cpu_rv = 1'b0;
    logic        m_ldr_rv = 1'b0;
    logic [15:0] m_cpu_pend = '0;
    logic [15:0] m_cpu_hold = '0;
    logic [15:0] m_ldr_pend = '0;
    logic [15:0] m_ldr_hold = '0;
    logic        m_lock_ack = 1'b0;

    int          exp_win;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_wen;
    logic        exp_cpu_rv;
    logic        exp_ldr_rv;
    logic [15:0] exp_cpu_rdata;
    logic [15:0] exp_ldr_rdata;

    // Expected bus and return values from the current inputs and model state.
    always_comb begin
        exp_win = 0;
        if (!rst) begin
            if (cpu_if.req && !ldr_lock && ldr_if.req) begin
                if (m_owner != 0 && m_burst < MAX_BURST) exp_win = m_owner;
                else if (m_owner == 1)                   exp_win = 2;
                else if (m_owner == 2)                   exp_win = 1;
                else                                     exp_win = 2;
            end else if (cpu_if.req && !ldr_lock) begin
                exp_win = 1;
            end else if (ldr_if.req) begin
                exp_win = 2;
            end
        end
        exp_addr      = (exp_win == 1) ? cpu_if.addr  : (exp_win == 2) ? ldr_if.addr  : m_last_addr;
        exp_wdata     = (exp_win == 1) ? cpu_if.wdata : (exp_win == 2) ? ldr_if.wdata : m_last_wdata;
        exp_wen       = (exp_win == 1) ? cpu_if.we    : (exp_win == 2) ? ldr_if.we    : 1'b0;
        exp_cpu_rv    = m_cpu_rv && !rst;
        exp_ldr_rv    = m_ldr_rv && !rst;
        exp_cpu_rdata = exp_cpu_rv ? m_cpu_pend : m_cpu_hold;
        exp_ldr_rdata = exp_ldr_rv ? m_ldr_pend : m_ldr_hold;
    end

    // Advance the model by one clock.
    always @(posedge clk) begin
        if (rst) begin
            m_owner      <= 0;
            m_burst      <= 0;
            m_last_addr  <= '0;
            m_last_wdata <= '0;
            m_cpu_rv     <= 1'b0;
            m_ldr_rv     <= 1'b0;
            m_cpu_hold   <= '0;
            m_ldr_hold   <= '0;
            m_lock_ack   <= 1'b0;
        end else begin
            if (exp_win == 0) begin
                m_owner <= 0;
                m_burst <= 0;
            end else if (exp_win == m_owner) begin
                m_burst <= (m_burst < MAX_BURST) ? m_burst + 1 : m_burst;
            end else begin
                m_owner <= exp_win;
                m_burst <= 1;
            end
            if (exp_win != 0) begin
                m_last_addr  <= exp_addr;
                m_last_wdata <= exp_wdata;
                if (exp_wen) begin
                    model_arr[exp_addr] <= exp_wdata;
                    model_wr[exp_addr]  <= 1'b1;
                end
            end
            if (m_cpu_rv) m_cpu_hold <= m_cpu_pend;
            if (m_ldr_rv) m_ldr_hold <= m_ldr_pend;
            m_cpu_rv <= (exp_win == 1) && !cpu_if.we;
            m_ldr_rv <= (exp_win == 2) && !ldr_if.we;
            if (exp_win != 0 && !exp_wen) begin
                if (exp_win == 1)
                    m_cpu_pend <= model_wr[exp_addr] ? model_arr[exp_addr] : init_word(exp_addr);
                else
                    m_ldr_pend <= model_wr[exp_addr] ? model_arr[exp_addr] : init_word(exp_addr);
            end
            m_lock_ack <= ldr_lock && !m_cpu_rv;
        end
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = '0; ldr_if.wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ldr_lock = 1'b0;
        idle_inputs();
        repeat (2) advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, ldr_if.gnt, cpu_if.rvalid, ldr_if.rvalid, lock_ack, mem_w_en} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000000",
                     {cpu_if.gnt, ldr_if.gnt, cpu_if.rvalid, ldr_if.rvalid, lock_ack, mem_w_en});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus got %h want 00000000", {mem_addr, mem_wdata});
        end
        checks++;
        if ({cpu_if.rdata, ldr_if.rdata} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %h want 00000000", {cpu_if.rdata, ldr_if.rdata});
        end
        advance();
    endtask

    task automatic test_single_read();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h3000;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, mem_w_en, mem_addr} !== {2'b10, 16'h3000}) begin
            errors++;
            $display("[TB] FAIL read_grant got gnt/wen/addr %b/%b/%h want 1/0/3000", cpu_if.gnt, mem_w_en, mem_addr);
        end
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({cpu_if.rvalid, cpu_if.rdata} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("[TB] FAIL read_return got rvalid/rdata %b/%h want 1/1234", cpu_if.rvalid, cpu_if.rdata);
        end
        advance();
        @(negedge clk);
        checks++;
        if ({cpu_if.rvalid, cpu_if.rdata, mem_addr} !== {1'b0, 16'h1234, 16'h3000}) begin
            errors++;
            $display("[TB] FAIL read_hold got rvalid/rdata/addr %b/%h/%h want 0/1234/3000",
                     cpu_if.rvalid, cpu_if.rdata, mem_addr);
        end
        advance();
    endtask

    task automatic test_contention();
        logic [11:0] ldr_turn;
        logic        l;
        ldr_turn = 12'b1111_0000_1111;
        rst = 1'b1;
        idle_inputs();
        advance();
        rst = 1'b0;
        cpu_if.req = 1'b1; cpu_if.addr = 16'h0100;
        ldr_if.req = 1'b1; ldr_if.addr = 16'h0200;
        for (int i = 0; i < 12; i++) begin
            l = ldr_turn[11 - i];
            @(negedge clk);
            checks++;
            if ({cpu_if.gnt, ldr_if.gnt} !== {~l, l}) begin
                errors++;
                $display("[TB] FAIL rr_grant[%0d] got cpu/ldr %b/%b want %b/%b", i, cpu_if.gnt, ldr_if.gnt, ~l, l);
            end
            checks++;
            if (mem_addr !== (l ? 16'h0200 : 16'h0100)) begin
                errors++;
                $display("[TB] FAIL rr_addr[%0d] got %h want %h", i, mem_addr, l ? 16'h0200 : 16'h0100);
            end
            advance();
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_write_then_read();
        ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 16'h0010; ldr_if.wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({ldr_if.gnt, mem_w_en, mem_addr, mem_wdata} !== {2'b11, 16'h0010, 16'hBEEF}) begin
            errors++;
            $display("[TB] FAIL ldr_write got gnt/wen/addr/data %b/%b/%h/%h want 1/1/0010/beef",
                     ldr_if.gnt, mem_w_en, mem_addr, mem_wdata);
        end
        advance();
        idle_inputs();
        cpu_if.req = 1'b1; cpu_if.addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, mem_w_en, ldr_if.rvalid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL cpu_readback_grant got gnt/wen/ldr_rvalid %b/%b/%b want 1/0/0",
                     cpu_if.gnt, mem_w_en, ldr_if.rvalid);
        end
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({cpu_if.rvalid, cpu_if.rdata} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("[TB] FAIL cpu_readback got rvalid/rdata %b/%h want 1/beef", cpu_if.rvalid, cpu_if.rdata);
        end
        advance();
    endtask

    task automatic test_lock();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0020;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_pre_grant got %b want 1", cpu_if.gnt);
        end
        advance();
        ldr_lock = 1'b1;
        cpu_if.addr = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_if.gnt, lock_ack} !== {1'b0, (i >= 2)}) begin
                errors++;
                $display("[TB] FAIL lock_cycle[%0d] got gnt/ack %b/%b want 0/%b", i, cpu_if.gnt, lock_ack, (i >= 2));
            end
            if (i == 0) begin
                checks++;
                if (cpu_if.rvalid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL lock_rvalid got %b want 1", cpu_if.rvalid);
                end
            end
            advance();
        end
        ldr_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, lock_ack} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL unlock_grant got gnt/ack %b/%b want 1/1", cpu_if.gnt, lock_ack);
        end
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (lock_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unlock_ack got %b want 0", lock_ack);
        end
        advance();
    endtask

    task automatic test_reset_mid_access();
        ldr_if.req = 1'b1; ldr_if.we = 1'b0; ldr_if.addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (ldr_if.gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_grant got %b want 1", ldr_if.gnt);
        end
        advance();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ldr_if.rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_rvalid got %b want 0", ldr_if.rvalid);
        end
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, ldr_if.gnt, cpu_if.rvalid, ldr_if.rvalid, lock_ack, mem_w_en,
             mem_addr, mem_wdata, cpu_if.rdata, ldr_if.rdata} !== 70'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs got addr/wdata/crd/lrd %h/%h/%h/%h ldr_rvalid %b want all 0",
                     mem_addr, mem_wdata, cpu_if.rdata, ldr_if.rdata, ldr_if.rvalid);
        end
        advance();
        cpu_if.req = 1'b1; cpu_if.addr = 16'h0050;
        ldr_if.req = 1'b1; ldr_if.addr = 16'h0060;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, ldr_if.gnt} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstmid_first_winner got cpu/ldr %b/%b want 0/1", cpu_if.gnt, ldr_if.gnt);
        end
        advance();
        idle_inputs();
        advance();
    endtask

    task automatic test_single_requester();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_if.addr = 16'h0400 + 16'(i);
            @(negedge clk);
            checks++;
            if ({cpu_if.gnt, ldr_if.gnt} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL solo_cpu[%0d] got cpu/ldr %b/%b want 1/0", i, cpu_if.gnt, ldr_if.gnt);
            end
            advance();
        end
        ldr_if.req = 1'b1; ldr_if.addr = 16'h0500;
        @(negedge clk);
        checks++;
        if ({cpu_if.gnt, ldr_if.gnt} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL solo_ldr_arrives got cpu/ldr %b/%b want 0/1", cpu_if.gnt, ldr_if.gnt);
        end
        advance();
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) ldr_lock = ~ldr_lock;
            cpu_if.req   = ($urandom_range(0, 3) != 0);
            cpu_if.we    = ($urandom_range(0, 2) == 0);
            cpu_if.addr  = 16'($urandom_range(0, 15));
            cpu_if.wdata = 16'($urandom);
            ldr_if.req   = ($urandom_range(0, 2) == 0);
            ldr_if.we    = ($urandom_range(0, 1) == 0);
            ldr_if.addr  = 16'($urandom_range(0, 15));
            ldr_if.wdata = 16'($urandom);
            @(negedge clk);
            checks++;
            if ({cpu_if.gnt, ldr_if.gnt} !== {exp_win == 1, exp_win == 2}) begin
                errors++;
                $display("[TB] FAIL rnd_gnt[%0d] got cpu/ldr %b/%b want winner %0d", n, cpu_if.gnt, ldr_if.gnt, exp_win);
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_w_en} !== {exp_addr, exp_wdata, exp_wen}) begin
                errors++;
                $display("[TB] FAIL rnd_bus[%0d] got %h/%h/%b want %h/%h/%b", n,
                         mem_addr, mem_wdata, mem_w_en, exp_addr, exp_wdata, exp_wen);
            end
            checks++;
            if ({cpu_if.rvalid, cpu_if.rdata} !== {exp_cpu_rv, exp_cpu_rdata}) begin
                errors++;
                $display("[TB] FAIL rnd_cpu_ret[%0d] got %b/%h want %b/%h", n,
                         cpu_if.rvalid, cpu_if.rdata, exp_cpu_rv, exp_cpu_rdata);
            end
            checks++;
            if ({ldr_if.rvalid, ldr_if.rdata} !== {exp_ldr_rv, exp_ldr_rdata}) begin
                errors++;
                $display("[TB] FAIL rnd_ldr_ret[%0d] got %b/%h want %b/%h", n,
                         ldr_if.rvalid, ldr_if.rdata, exp_ldr_rv, exp_ldr_rdata);
            end
            checks++;
            if (lock_ack !== m_lock_ack) begin
                errors++;
                $display("[TB] FAIL rnd_lock_ack[%0d] got %b want %b", n, lock_ack, m_lock_ack);
            end
            advance();
        end
        rst = 1'b0;
        ldr_lock = 1'b0;
        idle_inputs();
        advance();
    endtask

    initial begin
        idle_inputs();
        $display("[TB] punc_mem_arbiter bench starting");
        test_reset();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_lock();
        test_reset_mid_access();
        test_single_requester();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
